// File: rtl/fp_exc_classifier.sv
// fp_exc_classifier
// Multi-channel IEEE-754 operand classifier sitting between operand fetch and
// the FPU arithmetic units. Each channel's operand is classified into a 3-bit
// class code. The codes are returned through a one-entry valid/ready output
// register with 1-cycle latency. Sticky class flags and a saturating NaN-event
// counter are accumulated for the status/CSR logic.
//
// Ports:
//   CLK, RSTN     clock (rising edge), asynchronous active-low reset
//   in_valid      operand bundle valid
//   in_ready      bundle can be accepted (= !out_valid || out_ready)
//   in_data       NUM_CH slices of {sign, exponent, mantissa}; channel k in slice k
//   out_valid     classification result valid
//   out_ready     downstream accepts the result
//   out_exc       per-channel class code, channel k at [3k+2:3k]
//                 000 normal, 001 zero, 010 subnormal, 011 inf, 100 qNaN, 101 sNaN
//   out_any_nan   some channel of the held result is a NaN
//   sticky        {snan, qnan, inf, subnormal, zero}, set-only
//   clr_sticky    synchronous clear of sticky and nan_cnt
//   nan_cnt       accepted bundles containing a NaN, saturating
module fp_exc_classifier #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_CH*(1+EXP_W+MAN_W)-1:0] in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_CH*3-1:0]               out_exc,
    output logic                              out_any_nan,
    output logic [4:0]                        sticky,
    input  logic                              clr_sticky,
    output logic [CNT_W-1:0]                  nan_cnt
);

    localparam int SLICE_W = 1 + EXP_W + MAN_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CH*3-1:0]     out_exc_q, out_exc_d;
    logic                    out_any_nan_q, out_any_nan_d;
    logic [4:0]              sticky_q, sticky_d;
    logic [CNT_W-1:0]        nan_cnt_q, nan_cnt_d;

    logic [NUM_CH*3-1:0]     cls_codes;
    logic [NUM_CH-1:0][4:0]  ch_flags;
    logic [NUM_CH-1:0]       ch_nan;
    logic [NUM_CH-1:0]       sign_unused;

    // Per-channel classification; purely a function of the operand fields.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [EXP_W-1:0] exp_f;
            logic [MAN_W-1:0] man_f;
            logic [2:0]       code;

            assign exp_f          = in_data[gi*SLICE_W+MAN_W +: EXP_W];
            assign man_f          = in_data[gi*SLICE_W +: MAN_W];
            assign sign_unused[gi] = in_data[gi*SLICE_W+MAN_W+EXP_W];

            always_comb begin
                code = 3'b000;
                if (exp_f == '0) begin
                    code = (man_f == '0) ? 3'b001 : 3'b010;
                end else if (exp_f == '1) begin
                    if (man_f == '0) begin
                        code = 3'b011;
                    end else if (man_f[MAN_W-1]) begin
                        code = 3'b100;
                    end else begin
                        code = 3'b101;
                    end
                end
            end

            assign cls_codes[3*gi +: 3] = code;
            // Only the NaN codes have bit 2 set.
            assign ch_nan[gi]   = code[2];
            assign ch_flags[gi] = {code == 3'b101, code == 3'b100, code == 3'b011,
                                   code == 3'b010, code == 3'b001};
        end
    endgenerate

    assign in_ready = (state_q == EMPTY) || out_ready;

    always_comb begin
        logic             accept;
        logic [4:0]       bundle_flags;
        logic [CNT_W-1:0] cnt_base;

        accept       = in_valid && in_ready;
        bundle_flags = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bundle_flags = bundle_flags | ch_flags[k];
        end

        state_d       = state_q;
        out_exc_d     = out_exc_q;
        out_any_nan_d = out_any_nan_q;
        if (accept) begin
            state_d       = FULL;
            out_exc_d     = cls_codes;
            out_any_nan_d = |ch_nan;
        end else if (out_ready) begin
            state_d = EMPTY;
        end

        // Clear takes effect before the event of the same cycle is applied.
        sticky_d = (clr_sticky ? 5'b0 : sticky_q) | (accept ? bundle_flags : 5'b0);

        cnt_base  = clr_sticky ? '0 : nan_cnt_q;
        nan_cnt_d = cnt_base;
        if (accept && (|ch_nan) && (cnt_base != '1)) begin
            nan_cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= EMPTY;
            out_exc_q     <= '0;
            out_any_nan_q <= 1'b0;
            sticky_q      <= '0;
            nan_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            out_exc_q     <= out_exc_d;
            out_any_nan_q <= out_any_nan_d;
            sticky_q      <= sticky_d;
            nan_cnt_q     <= nan_cnt_d;
        end
    end

    assign out_valid   = (state_q == FULL);
    assign out_exc     = out_exc_q;
    assign out_any_nan = out_any_nan_q;
    assign sticky      = sticky_q;
    assign nan_cnt     = nan_cnt_q;

endmodule

// File: tb/tb_fp_exc_classifier.sv
// Testbench for fp_exc_classifier: a single-precision two-channel instance with
// a 3-bit NaN counter checked every cycle against a behavioural model, plus a
// one-channel double-precision instance checked with literal expectations.
module tb_fp_exc_classifier;

    localparam int CNT  = 3;
    localparam int CMAX = (1 << CNT) - 1;

    logic        CLK;
    logic        RSTN;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_exc;
    logic        out_any_nan;
    logic [4:0]  sticky;
    logic        clr_sticky;
    logic [CNT-1:0] nan_cnt;

    logic        in_valid1;
    logic        in_ready1;
    logic [63:0] in_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [2:0]  out_exc1;
    logic        out_any_nan1;
    logic [4:0]  sticky1;
    logic        clr_sticky1;
    logic [7:0]  nan_cnt1;

    int total = 0;
    int bad   = 0;

    fp_exc_classifier #(.EXP_W(8), .MAN_W(23), .NUM_CH(2), .CNT_W(CNT)) u_sp (
        .CLK(CLK), .RSTN(RSTN),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_exc(out_exc),
        .out_any_nan(out_any_nan), .sticky(sticky), .clr_sticky(clr_sticky),
        .nan_cnt(nan_cnt)
    );

    fp_exc_classifier #(.EXP_W(11), .MAN_W(52), .NUM_CH(1), .CNT_W(8)) u_dp (
        .CLK(CLK), .RSTN(RSTN),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_exc(out_exc1),
        .out_any_nan(out_any_nan1), .sticky(sticky1), .clr_sticky(clr_sticky1),
        .nan_cnt(nan_cnt1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Class of one operand from its exponent/mantissa fields, by plain arithmetic.
    function automatic int cls(input longint unsigned e, input longint unsigned m,
                               input int ew, input int mw);
        longint unsigned emax;
        emax = (64'd1 << ew) - 1;
        if (e == 0)          return (m == 0) ? 1 : 2;
        if (e != emax)       return 0;
        if (m == 0)          return 3;
        if (((m >> (mw - 1)) & 1) == 1) return 4;
        return 5;
    endfunction

    function automatic logic [5:0] bundle_codes(input logic [63:0] d);
        logic [5:0] r;
        r = '0;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] w;
            w = d[32*k +: 32];
            r[3*k +: 3] = 3'(cls(longint'(w[30:23]), longint'(w[22:0]), 8, 23));
        end
        return r;
    endfunction

    function automatic logic has_nan(input logic [5:0] c);
        return (c[2:0] == 3'd4) || (c[2:0] == 3'd5) || (c[5:3] == 3'd4) || (c[5:3] == 3'd5);
    endfunction

    // Flag bit for class c (1..5) is bit c-1; normal sets nothing.
    function automatic logic [4:0] flags_of(input logic [5:0] c);
        logic [4:0] f;
        f = '0;
        for (int k = 0; k < 2; k++) begin
            int v;
            v = int'(c[3*k +: 3]);
            if (v != 0) f = f | (5'd1 << (v - 1));
        end
        return f;
    endfunction

    logic       m_valid;
    logic [5:0] m_exc;
    logic       m_any;
    logic [4:0] m_sticky;
    int         m_cnt;
    logic       m_acc;

    assign m_acc = in_valid && (!m_valid || out_ready);

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_valid  <= 1'b0;
            m_exc    <= '0;
            m_any    <= 1'b0;
            m_sticky <= '0;
            m_cnt    <= 0;
        end else begin
            if (m_acc) begin
                m_valid <= 1'b1;
                m_exc   <= bundle_codes(in_data);
                m_any   <= has_nan(bundle_codes(in_data));
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            m_sticky <= (clr_sticky ? 5'b0 : m_sticky)
                        | (m_acc ? flags_of(bundle_codes(in_data)) : 5'b0);
            m_cnt <= (((clr_sticky ? 0 : m_cnt)
                        + ((m_acc && has_nan(bundle_codes(in_data))) ? 1 : 0)) > CMAX)
                     ? CMAX
                     : (clr_sticky ? 0 : m_cnt)
                       + ((m_acc && has_nan(bundle_codes(in_data))) ? 1 : 0);
        end
    end

    always @(negedge CLK) begin
        if (RSTN) begin
            chk("m.in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            chk("m.out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("m.out_exc", 64'(out_exc), 64'(m_exc));
                chk("m.any_nan", 64'(out_any_nan), 64'(m_any));
            end
            chk("m.sticky", 64'(sticky), 64'(m_sticky));
            chk("m.nan_cnt", 64'(nan_cnt), 64'(m_cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [63:0] d);
        in_data  = d;
        in_valid = 1'b1;
        $display("bundle ch1=%h ch0=%h out_ready=%0b clr=%0b", d[63:32], d[31:0],
                 out_ready, clr_sticky);
        cyc();
    endtask

    logic [63:0] b2b_vec [3];
    logic [5:0]  b2b_exp [3];

    initial begin
        RSTN = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_sticky = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1; clr_sticky1 = 1'b0;
        b2b_vec[0] = {32'h00000001, 32'h7F800001}; b2b_exp[0] = 6'b010_101;
        b2b_vec[1] = {32'h7F800000, 32'h3F800000}; b2b_exp[1] = 6'b011_000;
        b2b_vec[2] = {32'h7FC00000, 32'h00000000}; b2b_exp[2] = 6'b100_001;

        #3;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.sticky", 64'(sticky), 64'd0);
        chk("rst.nan_cnt", 64'(nan_cnt), 64'd0);
        chk("rst.out_exc", 64'(out_exc), 64'd0);
        cyc(); cyc();
        RSTN = 1'b1;
        cyc();

        // inf + qNaN
        drive({32'h7FC00000, 32'h7F800000});
        in_valid = 1'b0;
        chk("t1.out_valid", 64'(out_valid), 64'd1);
        chk("t1.out_exc", 64'(out_exc), 64'b100_011);
        chk("t1.any_nan", 64'(out_any_nan), 64'd1);
        chk("t1.sticky", 64'(sticky), 64'b01100);
        chk("t1.nan_cnt", 64'(nan_cnt), 64'd1);

        clr_sticky = 1'b1; cyc(); clr_sticky = 1'b0;
        chk("clr.sticky", 64'(sticky), 64'd0);
        chk("clr.nan_cnt", 64'(nan_cnt), 64'd0);

        // All remaining classes, sign ignored
        drive({32'h00000001, 32'h00000000});
        chk("cls.a", 64'(out_exc), 64'b010_001);
        drive({32'h3F800000, 32'h7F800001});
        chk("cls.b", 64'(out_exc), 64'b000_101);
        chk("cls.b_nan", 64'(out_any_nan), 64'd1);
        drive({32'h3F800000, 32'h80000000});
        chk("cls.c", 64'(out_exc), 64'b000_001);
        chk("cls.c_nan", 64'(out_any_nan), 64'd0);
        in_valid = 1'b0;
        cyc();
        chk("cls.sticky", 64'(sticky), 64'b10011);
        chk("cls.nan_cnt", 64'(nan_cnt), 64'd1);

        // Backpressure: first bundle held, later data ignored
        out_ready = 1'b0;
        drive({32'h00000000, 32'h7FC00000});
        for (int i = 0; i < 4; i++) begin
            in_data = {32'h7F800000, 32'h7F800001};
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            chk("bp.out_exc", 64'(out_exc), 64'b001_100);
            cyc();
        end
        chk("bp.nan_cnt", 64'(nan_cnt), 64'd2);

        // Back-to-back after release
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(b2b_vec[i]);
            chk("b2b.out_valid", 64'(out_valid), 64'd1);
            chk("b2b.out_exc", 64'(out_exc), 64'(b2b_exp[i]));
        end
        in_valid = 1'b0;
        cyc();
        chk("b2b.nan_cnt", 64'(nan_cnt), 64'd4);
        chk("b2b.drained", 64'(out_valid), 64'd0);

        // Saturation
        clr_sticky = 1'b1; cyc(); clr_sticky = 1'b0;
        for (int i = 0; i < 10; i++) drive({32'h3F800000, 32'h7FC00000});
        in_valid = 1'b0;
        chk("sat.nan_cnt", 64'(nan_cnt), 64'd7);
        clr_sticky = 1'b1;
        drive({32'h3F800000, 32'h7FC00000});
        clr_sticky = 1'b0; in_valid = 1'b0;
        chk("sat.clr_cnt", 64'(nan_cnt), 64'd1);
        chk("sat.clr_sticky", 64'(sticky), 64'b01000);

        // Reset while a result is held under backpressure
        out_ready = 1'b0;
        cyc();
        chk("rm.held", 64'(out_valid), 64'd1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("rm.out_valid", 64'(out_valid), 64'd0);
        chk("rm.sticky", 64'(sticky), 64'd0);
        chk("rm.nan_cnt", 64'(nan_cnt), 64'd0);
        chk("rm.in_ready", 64'(in_ready), 64'd1);
        cyc();
        RSTN = 1'b1;
        out_ready = 1'b1;
        cyc();

        // Double precision
        in_valid1 = 1'b1;
        in_data1 = 64'h7FF0000000000001; cyc();
        $display("dp bundle %h", in_data1);
        chk("dp.valid", 64'(out_valid1), 64'd1);
        chk("dp.snan", 64'(out_exc1), 64'b101);
        chk("dp.snan_any", 64'(out_any_nan1), 64'd1);
        in_data1 = 64'h7FF8000000000000; cyc();
        $display("dp bundle %h", in_data1);
        chk("dp.qnan", 64'(out_exc1), 64'b100);
        in_data1 = 64'h0010000000000000; cyc();
        $display("dp bundle %h", in_data1);
        chk("dp.normal", 64'(out_exc1), 64'b000);
        chk("dp.normal_any", 64'(out_any_nan1), 64'd0);
        in_valid1 = 1'b0;
        cyc();
        chk("dp.nan_cnt", 64'(nan_cnt1), 64'd2);
        chk("dp.sticky", 64'(sticky1), 64'b11000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
